// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MEM stage sequencer and the
//                MEM_WB store-select logic: sequencer state encoding, the
//                "no register write" writeback select and the default
//                memory wait limit.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // MEM stage sequencer states, with an explicit encoding width.
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } mem_state_t;

    // One-hot writeback select that targets no register.
    localparam logic [31:0] DSEL_NONE_DEFAULT = 32'h0000_0001;

    // Cycles in ACCESS without mem_ready before the access is abandoned.
    localparam int WAIT_MAX_DEFAULT = 15;

endpackage
`default_nettype wire

// File: rtl/wait_counter.sv
`default_nettype none
// ============================================================================
//  Module      : wait_counter
//  Description : Saturating up counter with synchronous clear and count
//                enable. The terminal output is high while the count equals
//                TERMINAL. The counter stops there rather than wrapping, so a
//                late enable can never alias back to a small count.
//  Ports       : clk, reset    - clock, synchronous active-high reset
//                clear         - force the count to zero (wins over enable)
//                enable        - advance the count by one
//                terminal      - count == TERMINAL
//  Revision    : 1.0 - initial release
// ============================================================================
module wait_counter #(
    parameter int WIDTH    = 4,
    parameter int TERMINAL = 14
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic terminal
);

    localparam logic [WIDTH-1:0] TC_VALUE = WIDTH'(TERMINAL);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != TC_VALUE)) begin
            count <= count + WIDTH'(1);
        end
    end

    assign terminal = (count == TC_VALUE);

endmodule
`default_nettype wire

// File: rtl/mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage_ctrl
//  Description : MEM stage sequencer for the pipelined MIPS core. Takes the
//                load/store held in EX/MEM, runs it against a variable-latency
//                data memory and stalls the front of the pipeline until the
//                memory answers or the wait limit expires. The result is then
//                offered to MEM_WB for exactly one cycle (DONE).
//  Ports       : clk, reset                   - clock, sync active-high reset
//                loadIn, storeIn               - request from EX/MEM
//                addrIn, storeDataIn, DselIn   - request operands
//                mem_ready, mem_rdata          - memory response
//                mem_req, mem_we               - memory strobes
//                daddrbus, databus             - memory address / write data
//                stall                         - freeze PC .. EX/MEM
//                wb_valid, wb_data, DselOut    - result for MEM_WB
//                bus_error                     - timeout pulse (DONE cycle)
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_ctrl
    import mips_pkg::*;
#(
    parameter int          WAIT_MAX  = WAIT_MAX_DEFAULT,
    parameter logic [31:0] DSEL_NONE = DSEL_NONE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        loadIn,
    input  logic        storeIn,
    input  logic [31:0] addrIn,
    input  logic [31:0] storeDataIn,
    input  logic [31:0] DselIn,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] daddrbus,
    output logic [31:0] databus,
    output logic        stall,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [31:0] DselOut,
    output logic        bus_error
);

    localparam int CNT_WIDTH = $clog2(WAIT_MAX + 1);

    mem_state_t  state;
    logic        op_store;     // latched op: 1 = store, 0 = load
    logic [31:0] dsel_latched; // destination select of the latched load
    logic        access;
    logic        wait_expired;

    assign access = loadIn | storeIn;

    // ------------------------------------------------------------------------
    // Wait counter: cleared when a request is accepted, so it reads 0 in the
    // first ACCESS cycle and WAIT_MAX-1 in the last one allowed.
    // ------------------------------------------------------------------------
    wait_counter #(
        .WIDTH    (CNT_WIDTH),
        .TERMINAL (WAIT_MAX - 1)
    ) u_wait_counter (
        .clk      (clk),
        .reset    (reset),
        .clear    ((state == S_IDLE) && access),
        .enable   (state == S_ACCESS),
        .terminal (wait_expired)
    );

    // ------------------------------------------------------------------------
    // Stall is the only combinational output. It must rise in the same cycle
    // the request shows up in EX/MEM, otherwise the next instruction would
    // overwrite EX/MEM before the access is latched. It is forced low during
    // reset so the pipeline is never frozen by a stale state value.
    // ------------------------------------------------------------------------
    assign stall = ~reset & (((state == S_IDLE) & access) | (state == S_ACCESS));

    // ------------------------------------------------------------------------
    // Sequencer with registered outputs. Memory-side outputs are set on the
    // edge that enters ACCESS and cleared on the edge that leaves it, so
    // mem_req is high for exactly the ACCESS cycles.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            op_store     <= 1'b0;
            dsel_latched <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            daddrbus     <= '0;
            databus      <= '0;
            wb_valid     <= 1'b0;
            wb_data      <= '0;
            DselOut      <= DSEL_NONE;
            bus_error    <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    wb_valid  <= 1'b0;
                    bus_error <= 1'b0;
                    DselOut   <= DSEL_NONE;
                    if (access) begin
                        // Store takes priority when both request bits are set.
                        op_store     <= storeIn;
                        dsel_latched <= DselIn;
                        daddrbus     <= addrIn;
                        databus      <= storeDataIn;
                        mem_req      <= 1'b1;
                        mem_we       <= storeIn;
                        state        <= S_ACCESS;
                    end
                end

                S_ACCESS: begin
                    if (mem_ready) begin
                        mem_req  <= 1'b0;
                        mem_we   <= 1'b0;
                        wb_valid <= 1'b1;
                        if (op_store) begin
                            wb_data <= '0;
                            DselOut <= DSEL_NONE;
                        end else begin
                            wb_data <= mem_rdata;
                            DselOut <= dsel_latched;
                        end
                        state <= S_DONE;
                    end else if (wait_expired) begin
                        // Abandon the access: no register is written back.
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        wb_valid  <= 1'b1;
                        wb_data   <= '0;
                        DselOut   <= DSEL_NONE;
                        bus_error <= 1'b1;
                        state     <= S_DONE;
                    end
                end

                S_DONE: begin
                    // Request inputs still show the completing instruction
                    // here, so they are not looked at. wb_data keeps its value.
                    wb_valid  <= 1'b0;
                    bus_error <= 1'b0;
                    DselOut   <= DSEL_NONE;
                    state     <= S_IDLE;
                end

                default: begin
                    mem_req   <= 1'b0;
                    mem_we    <= 1'b0;
                    wb_valid  <= 1'b0;
                    bus_error <= 1'b0;
                    DselOut   <= DSEL_NONE;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage_ctrl
//  Description : Directed self-checking bench for mem_stage_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_ctrl;

    localparam logic [31:0] NONE = 32'h0000_0001;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk;
    logic        reset;
    logic        loadIn;
    logic        storeIn;
    logic [31:0] addrIn;
    logic [31:0] storeDataIn;
    logic [31:0] DselIn;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] daddrbus;
    logic [31:0] databus;
    logic        stall;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [31:0] DselOut;
    logic        bus_error;

    int checks = 0;
    int passed = 0;

    mem_stage_ctrl #(
        .WAIT_MAX  (15),
        .DSEL_NONE (32'h0000_0001)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .loadIn      (loadIn),
        .storeIn     (storeIn),
        .addrIn      (addrIn),
        .storeDataIn (storeDataIn),
        .DselIn      (DselIn),
        .mem_ready   (mem_ready),
        .mem_rdata   (mem_rdata),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .daddrbus    (daddrbus),
        .databus     (databus),
        .stall       (stall),
        .wb_valid    (wb_valid),
        .wb_data     (wb_data),
        .DselOut     (DselOut),
        .bus_error   (bus_error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one request and walks it to its DONE cycle (bounded). The
    // memory answers in ACCESS cycle number ready_after (0-based); a negative
    // value means it never answers. Returns at the DONE sample point with
    // per-cycle counts and a snapshot of the DONE outputs.
    task automatic run_access(
        input  logic        ld,
        input  logic        st,
        input  logic [31:0] addr,
        input  logic [31:0] sdata,
        input  logic [31:0] dsel,
        input  logic [31:0] rdata,
        input  int          ready_after,
        output int          n_stall,
        output int          n_req,
        output int          n_we,
        output logic        done,
        output logic        d_stall,
        output logic [31:0] d_dsel,
        output logic [31:0] d_wdata,
        output logic        d_berr
    );
        int req_idx;
        loadIn = ld; storeIn = st; addrIn = addr; storeDataIn = sdata;
        DselIn = dsel; mem_ready = 1'b0; mem_rdata = JUNK;
        #1;
        n_stall = 0; n_req = 0; n_we = 0; done = 1'b0; req_idx = 0;
        d_stall = 1'b0; d_dsel = '0; d_wdata = '0; d_berr = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (wb_valid) begin
                done = 1'b1; d_stall = stall; d_dsel = DselOut;
                d_wdata = wb_data; d_berr = bus_error;
                break;
            end
            if (stall) n_stall++;
            if (mem_req) n_req++;
            if (mem_req && mem_we) n_we++;
            if (mem_req && req_idx == ready_after) begin
                mem_ready = 1'b1; mem_rdata = rdata;
            end else begin
                mem_ready = 1'b0; mem_rdata = JUNK;
            end
            if (mem_req) req_idx++;
            tick();
            loadIn = 1'b0; storeIn = 1'b0; mem_ready = 1'b0; mem_rdata = JUNK;
            #1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; loadIn = 1'b0; storeIn = 1'b0; addrIn = '0;
        storeDataIn = '0; DselIn = '0; mem_ready = 1'b0; mem_rdata = JUNK;
        tick(); tick();
        checks++; if ({mem_req, mem_we, wb_valid, bus_error} !== 4'b0000)
            $display("FAIL reset_strobes: got %b expected 0000", {mem_req, mem_we, wb_valid, bus_error});
        else passed++;
        checks++; if ({daddrbus, databus, wb_data} !== 96'h0)
            $display("FAIL reset_data: got %h expected 0", {daddrbus, databus, wb_data});
        else passed++;
        checks++; if (DselOut !== NONE)
            $display("FAIL reset_dsel: got %h expected %h", DselOut, NONE);
        else passed++;
        loadIn = 1'b1; #1;
        checks++; if (stall !== 1'b0)
            $display("FAIL reset_stall: got %b expected 0", stall);
        else passed++;
        loadIn = 1'b0; reset = 1'b0;
        // mem_ready while idle must be ignored.
        mem_ready = 1'b1; tick(); mem_ready = 1'b0; tick();
        checks++; if ({mem_req, wb_valid, stall} !== 3'b000)
            $display("FAIL idle_ready_ignored: got %b expected 000", {mem_req, wb_valid, stall});
        else passed++;
    endtask

    task automatic test_store_waits();
        int ns, nr, nw; logic dn, dst, be; logic [31:0] ds, wd;
        run_access(1'b0, 1'b1, 32'h20, 32'h55AA, 32'h4, 32'h0, 3,
                   ns, nr, nw, dn, dst, ds, wd, be);
        checks++; if (dn !== 1'b1) $display("FAIL store_done: got %b expected 1", dn); else passed++;
        checks++; if (nr !== 4 || nw !== 4)
            $display("FAIL store_req_cycles: got req=%0d we=%0d expected 4/4", nr, nw);
        else passed++;
        checks++; if (ns !== 5) $display("FAIL store_stall_cycles: got %0d expected 5", ns); else passed++;
        checks++; if (ds !== NONE || wd !== 32'h0 || be !== 1'b0 || dst !== 1'b0)
            $display("FAIL store_done_outputs: got dsel=%h data=%h berr=%b stall=%b expected %h/0/0/0", ds, wd, be, dst, NONE);
        else passed++;
        checks++; if (daddrbus !== 32'h20 || databus !== 32'h55AA)
            $display("FAIL store_bus_hold: got addr=%h data=%h expected 20/55aa", daddrbus, databus);
        else passed++;
        tick();
    endtask

    task automatic test_load_zero_wait();
        int ns, nr, nw; logic dn, dst, be; logic [31:0] ds, wd;
        run_access(1'b1, 1'b0, 32'h100, 32'h0, 32'h8, 32'hDEADBEEF, 0,
                   ns, nr, nw, dn, dst, ds, wd, be);
        checks++; if (dn !== 1'b1) $display("FAIL load_done: got %b expected 1", dn); else passed++;
        checks++; if (ns !== 2 || nr !== 1 || nw !== 0)
            $display("FAIL load_cycles: got stall=%0d req=%0d we=%0d expected 2/1/0", ns, nr, nw);
        else passed++;
        checks++; if (ds !== 32'h8 || wd !== 32'hDEADBEEF || be !== 1'b0)
            $display("FAIL load_result: got dsel=%h data=%h berr=%b expected 8/deadbeef/0", ds, wd, be);
        else passed++;
        checks++; if (daddrbus !== 32'h100)
            $display("FAIL load_addr: got %h expected 100", daddrbus);
        else passed++;
        tick();
        checks++; if (wb_valid !== 1'b0 || DselOut !== NONE || wb_data !== 32'hDEADBEEF)
            $display("FAIL load_after_done: got v=%b dsel=%h data=%h expected 0/%h/deadbeef", wb_valid, DselOut, wb_data, NONE);
        else passed++;
    endtask

    task automatic test_timeout();
        int ns, nr, nw; logic dn, dst, be; logic [31:0] ds, wd;
        run_access(1'b1, 1'b0, 32'h300, 32'h0, 32'h10, 32'h0, -1,
                   ns, nr, nw, dn, dst, ds, wd, be);
        checks++; if (dn !== 1'b1) $display("FAIL timeout_done: got %b expected 1", dn); else passed++;
        checks++; if (nr !== 15 || ns !== 16)
            $display("FAIL timeout_cycles: got req=%0d stall=%0d expected 15/16", nr, ns);
        else passed++;
        checks++; if (be !== 1'b1 || ds !== NONE)
            $display("FAIL timeout_result: got berr=%b dsel=%h expected 1/%h", be, ds, NONE);
        else passed++;
        tick();
        checks++; if ({bus_error, wb_valid, mem_req, stall} !== 4'b0000)
            $display("FAIL timeout_idle: got %b expected 0000", {bus_error, wb_valid, mem_req, stall});
        else passed++;
    endtask

    task automatic test_back_to_back();
        int ns, nr, nw; logic dn, dst, be; logic [31:0] ds, wd;
        run_access(1'b1, 1'b0, 32'h400, 32'h0, 32'h2, 32'h1111_2222, 1,
                   ns, nr, nw, dn, dst, ds, wd, be);
        checks++; if (dn !== 1'b1 || ds !== 32'h2 || wd !== 32'h1111_2222)
            $display("FAIL b2b_first: got done=%b dsel=%h data=%h expected 1/2/11112222", dn, ds, wd);
        else passed++;
        // Next instruction arrives while DONE is showing; it must not stall
        // or start an access in this cycle.
        storeIn = 1'b1; addrIn = 32'h404; storeDataIn = 32'h77; #1;
        checks++; if (mem_req !== 1'b0 || stall !== 1'b0)
            $display("FAIL b2b_done_cycle: got req=%b stall=%b expected 0/0", mem_req, stall);
        else passed++;
        tick();
        checks++; if (mem_req !== 1'b0 || wb_valid !== 1'b0 || stall !== 1'b1)
            $display("FAIL b2b_gap: got req=%b valid=%b stall=%b expected 0/0/1", mem_req, wb_valid, stall);
        else passed++;
        run_access(1'b0, 1'b1, 32'h404, 32'h77, 32'h2, 32'h0, 0,
                   ns, nr, nw, dn, dst, ds, wd, be);
        checks++; if (dn !== 1'b1 || nw !== 1 || ns !== 2 || ds !== NONE)
            $display("FAIL b2b_second: got done=%b we=%0d stall=%0d dsel=%h expected 1/1/2/%h", dn, nw, ns, ds, NONE);
        else passed++;
        tick();
        checks++; if (wb_valid !== 1'b0)
            $display("FAIL b2b_single_valid: got %b expected 0", wb_valid);
        else passed++;
    endtask

    task automatic test_both_ops();
        int ns, nr, nw; logic dn, dst, be; logic [31:0] ds, wd;
        run_access(1'b1, 1'b1, 32'h500, 32'hA5A5, 32'h20, 32'h9999, 1,
                   ns, nr, nw, dn, dst, ds, wd, be);
        checks++; if (dn !== 1'b1 || nr !== 2 || nw !== 2)
            $display("FAIL both_we: got done=%b req=%0d we=%0d expected 1/2/2", dn, nr, nw);
        else passed++;
        checks++; if (ds !== NONE || databus !== 32'hA5A5)
            $display("FAIL both_dsel: got dsel=%h data=%h expected %h/a5a5", ds, databus, NONE);
        else passed++;
        tick();
    endtask

    task automatic test_reset_mid_access();
        int ns, nr, nw; logic dn, dst, be; logic [31:0] ds, wd;
        loadIn = 1'b1; addrIn = 32'h600; DselIn = 32'h40; #1;
        tick();                       // first ACCESS cycle
        loadIn = 1'b0;
        tick();                       // second ACCESS cycle
        checks++; if (mem_req !== 1'b1)
            $display("FAIL rst_mid_pre: got req=%b expected 1", mem_req);
        else passed++;
        reset = 1'b1; #1;
        checks++; if (stall !== 1'b0)
            $display("FAIL rst_mid_stall: got %b expected 0", stall);
        else passed++;
        tick();
        checks++; if ({mem_req, wb_valid, bus_error, stall} !== 4'b0000)
            $display("FAIL rst_mid_edge: got %b expected 0000", {mem_req, wb_valid, bus_error, stall});
        else passed++;
        reset = 1'b0;
        tick(); tick();
        checks++; if ({mem_req, wb_valid, bus_error} !== 3'b000)
            $display("FAIL rst_mid_quiet: got %b expected 000", {mem_req, wb_valid, bus_error});
        else passed++;
        run_access(1'b1, 1'b0, 32'h604, 32'h0, 32'h40, 32'hCAFEF00D, 2,
                   ns, nr, nw, dn, dst, ds, wd, be);
        checks++; if (dn !== 1'b1 || ns !== 4 || ds !== 32'h40 || wd !== 32'hCAFEF00D || be !== 1'b0)
            $display("FAIL rst_mid_fresh: got done=%b stall=%0d dsel=%h data=%h berr=%b expected 1/4/40/cafef00d/0", dn, ns, ds, wd, be);
        else passed++;
        tick();
    endtask

    initial begin
        test_reset();
        test_store_waits();
        test_load_zero_wait();
        test_timeout();
        test_back_to_back();
        test_both_ops();
        test_reset_mid_access();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
`default_nettype wire
